// File: rtl/dlx_step_ctrl.sv
// Run/single-step sequencer for the DLX core: debounced step button, free-run,
// PC breakpoint, HALT stop and per-instruction watchdog driving the core clock enable.
module dlx_step_ctrl #(
  parameter int unsigned DEB_CYCLES     = 4,
  parameter int unsigned INIT_CYCLES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             CLK_IN,
  input  logic             RESET_N,
  input  logic             STEP_IN,
  input  logic             RUN_IN,
  input  logic             HALT_IN,
  input  logic             INSTR_DONE,
  input  logic [31:0]      PC,
  input  logic             BP_EN,
  input  logic [31:0]      BP_ADDR,
  output logic             DLX_CE,
  output logic             IN_INIT,
  output logic             STEP_DONE,
  output logic             TIMEOUT,
  output logic [CNT_W-1:0] INSTR_CNT,
  output logic [2:0]       STATE
);

  localparam int unsigned DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int unsigned INIT_W = $clog2(INIT_CYCLES + 1);
  localparam int unsigned WD_W   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_STEP  = 3'd2,
    S_RUN   = 3'd3,
    S_BREAK = 3'd4,
    S_HALT  = 3'd5,
    S_FAULT = 3'd6
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        sync_q;
  logic              stable;
  logic [DEB_W-1:0]  deb_cnt;
  logic              step_req;
  logic [INIT_W-1:0] init_cnt, init_cnt_nxt;
  logic [WD_W-1:0]   wd_cnt, wd_cnt_nxt;
  logic              rearm, rearm_nxt;
  logic              cnt_inc;
  logic              done_nxt;
  logic              timeout_set;

  // Button debouncer; stable resets high so a button held through reset is not a press
  always_ff @(posedge CLK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q   <= 2'b00;
      stable   <= 1'b1;
      deb_cnt  <= '0;
      step_req <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], STEP_IN};
      step_req <= 1'b0;
      if (sync_q[1] == stable) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        stable   <= sync_q[1];
        deb_cnt  <= '0;
        step_req <= sync_q[1];
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  // Next-state, watchdog and status decode
  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    wd_cnt_nxt   = wd_cnt;
    rearm_nxt    = rearm;
    cnt_inc      = 1'b0;
    done_nxt     = 1'b0;
    timeout_set  = 1'b0;

    case (state)
      S_INIT: begin
        if (init_cnt == INIT_W'(INIT_CYCLES - 1)) state_nxt = S_IDLE;
        else init_cnt_nxt = init_cnt + INIT_W'(1);
      end
      S_IDLE: begin
        if (step_req)    state_nxt = S_STEP;
        else if (RUN_IN) state_nxt = S_RUN;
      end
      S_STEP: begin
        if (INSTR_DONE) begin
          cnt_inc    = 1'b1;
          done_nxt   = 1'b1;
          wd_cnt_nxt = '0;
          state_nxt  = HALT_IN ? S_HALT : S_IDLE;
        end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt   = S_FAULT;
          timeout_set = 1'b1;
        end else begin
          wd_cnt_nxt = wd_cnt + WD_W'(1);
        end
      end
      S_RUN: begin
        if (INSTR_DONE) begin
          cnt_inc    = 1'b1;
          wd_cnt_nxt = '0;
          if (HALT_IN)                       state_nxt = S_HALT;
          else if (BP_EN && (PC == BP_ADDR)) state_nxt = S_BREAK;
          else if (!RUN_IN)                  state_nxt = S_IDLE;
        end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt   = S_FAULT;
          timeout_set = 1'b1;
        end else begin
          wd_cnt_nxt = wd_cnt + WD_W'(1);
        end
      end
      S_BREAK: begin
        if (step_req)             state_nxt = S_STEP;
        else if (rearm && RUN_IN) state_nxt = S_RUN;
        if (!RUN_IN) rearm_nxt = 1'b1;
      end
      S_HALT:  state_nxt = S_HALT;
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_FAULT;
    endcase

    // Fresh watchdog window on every entry into an executing state
    if ((state_nxt != state) && ((state_nxt == S_STEP) || (state_nxt == S_RUN)))
      wd_cnt_nxt = '0;
    if (state != S_BREAK) rearm_nxt = 1'b0;
  end

  always_ff @(posedge CLK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= S_INIT;
      init_cnt  <= '0;
      wd_cnt    <= '0;
      rearm     <= 1'b0;
      DLX_CE    <= 1'b0;
      IN_INIT   <= 1'b1;
      STEP_DONE <= 1'b0;
      TIMEOUT   <= 1'b0;
      INSTR_CNT <= '0;
    end else begin
      state     <= state_nxt;
      init_cnt  <= init_cnt_nxt;
      wd_cnt    <= wd_cnt_nxt;
      rearm     <= rearm_nxt;
      DLX_CE    <= (state_nxt == S_STEP) || (state_nxt == S_RUN);
      IN_INIT   <= (state_nxt == S_INIT);
      STEP_DONE <= done_nxt;
      TIMEOUT   <= TIMEOUT | timeout_set;
      if (cnt_inc) INSTR_CNT <= INSTR_CNT + CNT_W'(1);
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_dlx_step_ctrl.sv
// Directed bench for dlx_step_ctrl: step timing, debounce, breakpoint, watchdog, halt, reset.
module tb_dlx_step_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        step_in = 1'b0;
  logic        run_in = 1'b0;
  logic        halt_in = 1'b0;
  logic        instr_done = 1'b0;
  logic [31:0] pc = '0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = '0;
  logic        dlx_ce, in_init, step_done, timeout;
  logic [15:0] instr_cnt;
  logic [2:0]  state;

  int total = 0;
  int bad = 0;

  dlx_step_ctrl dut (
    .CLK_IN    (clk),
    .RESET_N   (rst_n),
    .STEP_IN   (step_in),
    .RUN_IN    (run_in),
    .HALT_IN   (halt_in),
    .INSTR_DONE(instr_done),
    .PC        (pc),
    .BP_EN     (bp_en),
    .BP_ADDR   (bp_addr),
    .DLX_CE    (dlx_ce),
    .IN_INIT   (in_init),
    .STEP_DONE (step_done),
    .TIMEOUT   (timeout),
    .INSTR_CNT (instr_cnt),
    .STATE     (state)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input int n);
    step_in = 1'b1;
    tick_n(n);
    step_in = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_ce"}, 32'(dlx_ce), 32'd0);
    check({tag, "_init"}, 32'(in_init), 32'd1);
    check({tag, "_sdone"}, 32'(step_done), 32'd0);
    check({tag, "_tmo"}, 32'(timeout), 32'd0);
    check({tag, "_cnt"}, 32'(instr_cnt), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick_n(10);
  endtask

  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #5 check_reset_vals("rst_async");
    tick_n(2);
    check_reset_vals("rst_held");

    // INIT lasts two cycles after release
    rst_n = 1'b1;
    check("init_c0", 32'(in_init), 32'd1);
    tick();
    check("init_c1", 32'(in_init), 32'd1);
    check("init_c1_state", 32'(state), 32'd0);
    tick();
    check("init_done", 32'(in_init), 32'd0);
    check("idle_state", 32'(state), 32'd1);
    check("idle_ce", 32'(dlx_ce), 32'd0);
    check("idle_cnt", 32'(instr_cnt), 32'd0);
    tick_n(8);

    // Single step: STEP_IN high for edges 1..4, enable rises after edge 7
    step_in = 1'b1;
    tick_n(4);
    step_in = 1'b0;
    tick_n(2);
    check("step_e6_ce", 32'(dlx_ce), 32'd0);
    check("step_e6_state", 32'(state), 32'd1);
    tick();
    check("step_e7_ce", 32'(dlx_ce), 32'd1);
    check("step_e7_state", 32'(state), 32'd2);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("step_ce_hold", 32'(dlx_ce), 32'd1);
    end
    instr_done = 1'b1;
    pc = 32'h4;
    tick();
    instr_done = 1'b0;
    check("step_end_ce", 32'(dlx_ce), 32'd0);
    check("step_done_pulse", 32'(step_done), 32'd1);
    check("step_cnt", 32'(instr_cnt), 32'd1);
    check("step_end_state", 32'(state), 32'd1);
    tick();
    check("step_done_clear", 32'(step_done), 32'd0);
    tick_n(6);

    // Short pulses are rejected
    press(2);
    tick_n(12);
    check("glitch2_state", 32'(state), 32'd1);
    check("glitch2_ce", 32'(dlx_ce), 32'd0);
    press(3);
    tick_n(12);
    check("glitch3_state", 32'(state), 32'd1);
    check("glitch3_cnt", 32'(instr_cnt), 32'd1);

    // Button held through reset is not a press
    step_in = 1'b1;
    tick_n(2);
    rst_n = 1'b0;
    tick_n(2);
    rst_n = 1'b1;
    tick_n(15);
    check("held_state", 32'(state), 32'd1);
    check("held_ce", 32'(dlx_ce), 32'd0);
    check("held_cnt", 32'(instr_cnt), 32'd0);
    step_in = 1'b0;
    tick_n(10);
    check("held_release_state", 32'(state), 32'd1);

    // Free-run into a breakpoint at 0x10
    bp_en = 1'b1;
    bp_addr = 32'h10;
    run_in = 1'b1;
    tick();
    check("run_state", 32'(state), 32'd3);
    check("run_ce", 32'(dlx_ce), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      tick_n(2);
      instr_done = 1'b1;
      pc = 32'(4 * i);
      tick();
      instr_done = 1'b0;
      if (i < 4) check("run_continue", 32'(state), 32'd3);
    end
    check("bp_state", 32'(state), 32'd4);
    check("bp_cnt", 32'(instr_cnt), 32'd4);
    check("bp_ce", 32'(dlx_ce), 32'd0);
    tick_n(3);
    check("bp_hold", 32'(state), 32'd4);
    run_in = 1'b0;
    tick();
    check("bp_rearm", 32'(state), 32'd4);
    run_in = 1'b1;
    tick();
    check("bp_resume", 32'(state), 32'd3);
    check("bp_resume_ce", 32'(dlx_ce), 32'd1);
    run_in = 1'b0;
    tick_n(2);
    check("run_drop_mid", 32'(state), 32'd3);
    instr_done = 1'b1;
    pc = 32'h14;
    tick();
    instr_done = 1'b0;
    check("run_stop_state", 32'(state), 32'd1);
    check("run_stop_cnt", 32'(instr_cnt), 32'd5);
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    check("idle_done_ignored", 32'(instr_cnt), 32'd5);

    // Watchdog: completion in the last allowed cycle wins, then a full silent window faults
    bp_en = 1'b0;
    run_in = 1'b1;
    tick();
    check("wd_run", 32'(state), 32'd3);
    tick_n(63);
    check("wd_63", 32'(state), 32'd3);
    instr_done = 1'b1;
    pc = 32'h100;
    tick();
    instr_done = 1'b0;
    check("wd_done_prio", 32'(state), 32'd3);
    check("wd_done_cnt", 32'(instr_cnt), 32'd6);
    tick_n(63);
    check("wd_pre_fault", 32'(state), 32'd3);
    check("wd_pre_tmo", 32'(timeout), 32'd0);
    tick();
    check("wd_fault", 32'(state), 32'd6);
    check("wd_tmo", 32'(timeout), 32'd1);
    check("wd_ce", 32'(dlx_ce), 32'd0);
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    check("fault_done_ignored", 32'(instr_cnt), 32'd6);
    run_in = 1'b0;

    // HALT is terminal
    do_reset();
    check("halt_pre_state", 32'(state), 32'd1);
    check("halt_pre_tmo", 32'(timeout), 32'd0);
    run_in = 1'b1;
    tick();
    tick_n(2);
    halt_in = 1'b1;
    instr_done = 1'b1;
    pc = 32'h20;
    tick();
    instr_done = 1'b0;
    halt_in = 1'b0;
    check("halt_state", 32'(state), 32'd5);
    check("halt_ce", 32'(dlx_ce), 32'd0);
    check("halt_cnt", 32'(instr_cnt), 32'd1);
    press(6);
    tick_n(10);
    check("halt_step_ignored", 32'(state), 32'd5);
    check("halt_step_ce", 32'(dlx_ce), 32'd0);

    // Asynchronous reset in the middle of a run
    run_in = 1'b0;
    do_reset();
    run_in = 1'b1;
    tick();
    tick_n(2);
    instr_done = 1'b1;
    pc = 32'h30;
    tick();
    instr_done = 1'b0;
    check("midrun_cnt", 32'(instr_cnt), 32'd1);
    check("midrun_ce", 32'(dlx_ce), 32'd1);
    #5 rst_n = 1'b0;
    #1 check_reset_vals("rst_midrun");
    rst_n = 1'b1;
    run_in = 1'b0;
    tick_n(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
